// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar trig/echo responder.
// Defaults assume the 43.904 MHz sonar clock (256 cycles per mm round trip).
package sonar_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      TRIG_HIGH   = 3'd1,
      BURST_DELAY = 3'd2,
      ECHO        = 3'd3,
      HOLDOFF     = 3'd4
   } state_e;

   localparam int CNT_W  = 22;
   localparam int DIST_W = 12;
   localparam int MEAS_W = 16;

   localparam int DEF_CYCLES_PER_MM   = 256;
   localparam int DEF_MIN_TRIG_CYC    = 440;
   localparam int DEF_BURST_DELAY_CYC = 8781;
   localparam int DEF_MAX_MM          = 4000;
   localparam int DEF_TIMEOUT_CYC     = 1668352;
   localparam int DEF_HOLDOFF_CYC     = 439040;

   function automatic longint unsigned max2(
      input longint unsigned a,
      input longint unsigned b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sonar_echo_responder_if.sv
// Trig/echo link between a ranging initiator and the responder.
// The initiator is master, the sensor model is slave.
interface sonar_echo_responder_if;
   import sonar_pkg::*;

   logic              trig;
   logic [DIST_W-1:0] distance_mm;
   logic              no_target;
   logic              echo;
   logic              busy;
   logic [MEAS_W-1:0] meas_count;
   logic              short_trig;
   logic              trig_ignored;

   modport master (
      output trig, distance_mm, no_target,
      input  echo, busy, meas_count, short_trig, trig_ignored
   );

   modport slave (
      input  trig, distance_mm, no_target,
      output echo, busy, meas_count, short_trig, trig_ignored
   );

endinterface

// File: rtl/sonar_sync.sv
// Two-flop synchronizer for asynchronous sensor-side inputs.
// Also reused on the initiator side for the returning echo.
module sonar_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/sonar_echo_responder.sv
// Ultrasonic ranging sensor model: answers an accepted trig pulse
// with an echo whose width encodes the programmed distance.
module sonar_echo_responder
   import sonar_pkg::*;
#(
   parameter int CYCLES_PER_MM   = DEF_CYCLES_PER_MM,
   parameter int MIN_TRIG_CYC    = DEF_MIN_TRIG_CYC,
   parameter int BURST_DELAY_CYC = DEF_BURST_DELAY_CYC,
   parameter int MAX_MM          = DEF_MAX_MM,
   parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
   parameter int HOLDOFF_CYC     = DEF_HOLDOFF_CYC
) (
   input logic clk,
   input logic rst,
   sonar_echo_responder_if.slave bus
);

   localparam longint unsigned NEED =
      max2(max2(longint'(4095) * longint'(CYCLES_PER_MM),
                longint'(TIMEOUT_CYC)),
           max2(longint'(BURST_DELAY_CYC),
                longint'(HOLDOFF_CYC)));
   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   if (NEED > CNT_MAX) begin : g_cnt_w_chk
      $error("CNT_W too narrow for timing parameters");
   end

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_TRIG_CYC);
   localparam logic [CNT_W-1:0] BD_M1   = CNT_W'(BURST_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] HO_M1   = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_W   = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] MM_W    = CNT_W'(CYCLES_PER_MM);
   localparam logic [DIST_W:0]  MAX_D   = (DIST_W+1)'(MAX_MM);

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  w_q;
   logic [CNT_W-1:0]  w_calc;
   logic [MEAS_W-1:0] meas_q;
   logic              echo_q;
   logic              short_q;
   logic              ign_q;
   logic              trig_s;
   logic              trig_q;
   logic              rise;
   logic              fall;

   sonar_sync #(.W(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.trig),
      .q   (trig_s)
   );

   assign rise = trig_s & ~trig_q;
   assign fall = ~trig_s & trig_q;

   // Zero distance still yields one mm of echo so the pulse is never empty.
   always_comb begin
      w_calc = CNT_W'(bus.distance_mm) * MM_W;
      if (bus.no_target || ({1'b0, bus.distance_mm} > MAX_D))
         w_calc = TMO_W;
      else if (bus.distance_mm == '0)
         w_calc = MM_W;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         w_q     <= '0;
         meas_q  <= '0;
         echo_q  <= 1'b0;
         short_q <= 1'b0;
         ign_q   <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         trig_q  <= trig_s;
         short_q <= 1'b0;
         ign_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= TRIG_HIGH;
                  cnt   <= ONE;
               end
            end
            TRIG_HIGH: begin
               if (fall) begin
                  if (cnt >= MIN_W) begin
                     state  <= BURST_DELAY;
                     cnt    <= BD_M1;
                     w_q    <= w_calc;
                     meas_q <= meas_q + MEAS_W'(1);
                  end else begin
                     state   <= IDLE;
                     short_q <= 1'b1;
                  end
               end else if (cnt != '1) begin
                  cnt <= cnt + ONE;
               end
            end
            BURST_DELAY: begin
               ign_q <= rise;
               if (cnt == '0) begin
                  state  <= ECHO;
                  echo_q <= 1'b1;
                  cnt    <= w_q - ONE;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            ECHO: begin
               ign_q <= rise;
               if (cnt == '0) begin
                  state  <= HOLDOFF;
                  echo_q <= 1'b0;
                  cnt    <= HO_M1;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            HOLDOFF: begin
               ign_q <= rise;
               if (cnt == '0)
                  state <= IDLE;
               else
                  cnt <= cnt - ONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.echo         = echo_q;
   assign bus.busy         = (state != IDLE);
   assign bus.meas_count   = meas_q;
   assign bus.short_trig   = short_q;
   assign bus.trig_ignored = ign_q;

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Directed bench for the sonar echo responder with shortened timing.
// Table rows cover single measurements; sequences cover multi-cycle cases.
module tb_sonar_echo_responder;

   localparam int CPM = 4;
   localparam int MIN = 10;
   localparam int BD  = 20;
   localparam int TMO = 500;
   localparam int HO  = 50;
   localparam int RISE_EXP = BD + 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   ign_cnt = 0;
   int   short_cnt = 0;

   sonar_echo_responder_if ifc ();

   sonar_echo_responder #(
      .CYCLES_PER_MM   (CPM),
      .MIN_TRIG_CYC    (MIN),
      .BURST_DELAY_CYC (BD),
      .MAX_MM          (4000),
      .TIMEOUT_CYC     (TMO),
      .HOLDOFF_CYC     (HO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ifc.trig_ignored) ign_cnt++;
      if (ifc.short_trig) short_cnt++;
   end

   typedef struct {
      int          hi;
      logic [11:0] d;
      logic        nt;
      int          rise;
      int          wid;
      int          hold;
      int          meas;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic run_meas(
      input  int          hi,
      input  logic [11:0] d,
      input  logic        nt,
      output int          rise,
      output int          wid,
      output int          hold
   );
      ifc.distance_mm = d;
      ifc.no_target   = nt;
      ifc.trig        = 1'b1;
      repeat (hi) tick();
      ifc.trig = 1'b0;
      rise = 0;
      while (!ifc.echo && rise < 2000) begin tick(); rise++; end
      wid = 0;
      while (ifc.echo && wid < 20000) begin tick(); wid++; end
      hold = 0;
      while (ifc.busy && hold < 2000) begin tick(); hold++; end
   endtask

   task automatic run_short(input int hi, input int meas_exp);
      int s0;
      int echo_hi;
      s0 = short_cnt;
      echo_hi = 0;
      ifc.trig = 1'b1;
      repeat (hi) tick();
      ifc.trig = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ifc.echo) echo_hi++;
      end
      chk($sformatf("short%0d_pulse", hi), short_cnt - s0, 1);
      chk($sformatf("short%0d_echo", hi), echo_hi, 0);
      chk($sformatf("short%0d_meas", hi), ifc.meas_count, meas_exp);
      chk($sformatf("short%0d_busy", hi), ifc.busy, 0);
   endtask

   initial begin
      int r, w, h, ig0;

      vecs[0] = '{12, 12'd100,  1'b0, RISE_EXP, 400,   HO, 1};
      vecs[1] = '{12, 12'd4001, 1'b0, RISE_EXP, TMO,   HO, 2};
      vecs[2] = '{12, 12'd50,   1'b1, RISE_EXP, TMO,   HO, 3};
      vecs[3] = '{12, 12'd0,    1'b0, RISE_EXP, 4,     HO, 4};
      vecs[4] = '{12, 12'd4000, 1'b0, RISE_EXP, 16000, HO, 5};
      vecs[5] = '{MIN, 12'd1,   1'b0, RISE_EXP, 4,     HO, 6};

      ifc.trig = 1'b0;
      ifc.distance_mm = '0;
      ifc.no_target = 1'b0;
      repeat (3) tick();
      chk("rst_echo", ifc.echo, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_meas", ifc.meas_count, 0);
      chk("rst_short", ifc.short_trig, 0);
      chk("rst_ign", ifc.trig_ignored, 0);
      rst = 1'b1;
      repeat (3) tick();

      foreach (vecs[i]) begin
         run_meas(vecs[i].hi, vecs[i].d, vecs[i].nt, r, w, h);
         chk($sformatf("v%0d_rise", i), r, vecs[i].rise);
         chk($sformatf("v%0d_width", i), w, vecs[i].wid);
         chk($sformatf("v%0d_hold", i), h, vecs[i].hold);
         chk($sformatf("v%0d_meas", i), ifc.meas_count, vecs[i].meas);
         repeat (3) tick();
      end

      run_short(6, 6);
      run_short(MIN - 1, 6);

      // Re-trigger during ECHO and HOLDOFF, distance changed mid-echo.
      ifc.distance_mm = 12'd30;
      ifc.no_target = 1'b0;
      ifc.trig = 1'b1;
      repeat (12) tick();
      ifc.trig = 1'b0;
      r = 0;
      while (!ifc.echo && r < 2000) begin tick(); r++; end
      chk("rt_rise", r, RISE_EXP);
      ig0 = ign_cnt;
      w = 0;
      while (ifc.echo && w < 20000) begin
         if (w == 5) ifc.distance_mm = 12'd7;
         if (w == 20) ifc.trig = 1'b1;
         if (w == 23) ifc.trig = 1'b0;
         tick();
         w++;
      end
      chk("rt_width", w, 120);
      chk("rt_ign_echo", ign_cnt - ig0, 1);
      h = 0;
      while (ifc.busy && h < 2000) begin
         if (h == 10) ifc.trig = 1'b1;
         if (h == 13) ifc.trig = 1'b0;
         tick();
         h++;
      end
      chk("rt_hold", h, HO);
      chk("rt_ign_total", ign_cnt - ig0, 2);
      chk("rt_meas", ifc.meas_count, 7);
      repeat (3) tick();
      run_meas(12, 12'd25, 1'b0, r, w, h);
      chk("rt_next_rise", r, RISE_EXP);
      chk("rt_next_width", w, 100);
      chk("rt_next_meas", ifc.meas_count, 8);

      // Reset 100 cycles into ECHO.
      ifc.distance_mm = 12'd100;
      ifc.trig = 1'b1;
      repeat (12) tick();
      ifc.trig = 1'b0;
      r = 0;
      while (!ifc.echo && r < 2000) begin tick(); r++; end
      chk("mr_rise", r, RISE_EXP);
      repeat (100) tick();
      chk("mr_echo_pre", ifc.echo, 1);
      rst = 1'b0;
      #1;
      chk("mr_echo", ifc.echo, 0);
      chk("mr_busy", ifc.busy, 0);
      chk("mr_meas", ifc.meas_count, 0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (3) tick();
      run_meas(12, 12'd10, 1'b0, r, w, h);
      chk("mr_next_rise", r, RISE_EXP);
      chk("mr_next_width", w, 40);
      chk("mr_next_hold", h, HO);
      chk("mr_next_meas", ifc.meas_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
